// File: rtl/knn_ctrl.sv
// Sequencing controller for one k-NN classification pass: clears the top-5
// selector, streams training pairs, aligns selector valid, drains, then votes.
module knn_ctrl #(
  parameter int N_TRAIN  = 64,
  parameter int ADDR_W   = 6,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              sel_reset,
  output logic              sel_valid,
  input  logic [1:0]        class1,
  input  logic [1:0]        class2,
  input  logic [1:0]        class3,
  input  logic [1:0]        class4,
  input  logic [1:0]        class5,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result_class,
  output logic [2:0]        dbg_state
);

  localparam int N_PAIRS = N_TRAIN / 2;
  localparam int P_W     = ADDR_W - 1;
  localparam int D_W     = $clog2(PIPE_LAT + 1);
  localparam logic [P_W-1:0] P_LAST = P_W'(N_PAIRS - 1);
  localparam logic [D_W-1:0] D_LAST = D_W'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_VOTE  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Handshake: rd_en qualifies rd_addr_a/b for exactly one cycle each;
  // sel_valid is rd_en delayed PIPE_LAT cycles, with no back-pressure.
  state_t               r_state;
  state_t               w_next;
  logic [P_W-1:0]       r_p;
  logic [D_W-1:0]       r_dcnt;
  logic [PIPE_LAT-1:0]  r_sr;
  logic [PIPE_LAT:0]    w_sr_ext;
  logic [1:0]           r_result;
  logic                 w_rd_en;
  logic [1:0]           w_cls [5];
  logic [2:0]           w_cnt [4];
  logic [1:0]           w_winner;
  logic [2:0]           w_best_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // abort dominates everything, including start in IDLE
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_CLEAR;
        S_CLEAR: w_next = S_ISSUE;
        S_ISSUE: if (r_p == P_LAST) w_next = S_DRAIN;
        S_DRAIN: if (r_dcnt == D_LAST) w_next = S_VOTE;
        S_VOTE:  w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_en   = 1'b0;
    sel_reset = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE:  busy      = 1'b0;
      S_CLEAR: sel_reset = 1'b1;
      S_ISSUE: w_rd_en   = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  // Pair counter only moves on entry to / inside ISSUE, so the addresses
  // hold their last value whenever rd_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p <= '0;
    end else if (r_state == S_CLEAR && w_next == S_ISSUE) begin
      r_p <= '0;
    end else if (r_state == S_ISSUE && w_next == S_ISSUE) begin
      r_p <= r_p + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dcnt <= '0;
    end else if (r_state != S_DRAIN) begin
      r_dcnt <= '0;
    end else begin
      r_dcnt <= r_dcnt + 1'b1;
    end
  end

  assign w_sr_ext = {r_sr, w_rd_en};

  always_ff @(posedge clk) begin
    if (reset || abort || r_state == S_CLEAR) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_sr_ext[PIPE_LAT-1:0];
    end
  end

  assign w_cls[0] = class1;
  assign w_cls[1] = class2;
  assign w_cls[2] = class3;
  assign w_cls[3] = class4;
  assign w_cls[4] = class5;

  // Strict '>' while scanning nearest-first keeps the earliest tied class.
  always_comb begin
    for (int c = 0; c < 4; c++) w_cnt[c] = 3'd0;
    for (int i = 0; i < 5; i++) w_cnt[w_cls[i]] = w_cnt[w_cls[i]] + 3'd1;
    w_winner   = w_cls[0];
    w_best_cnt = w_cnt[w_cls[0]];
    for (int i = 1; i < 5; i++) begin
      if (w_cnt[w_cls[i]] > w_best_cnt) begin
        w_winner   = w_cls[i];
        w_best_cnt = w_cnt[w_cls[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= 2'd0;
    end else if (r_state == S_VOTE && !abort) begin
      r_result <= w_winner;
    end
  end

  assign rd_en        = w_rd_en;
  assign rd_addr_a    = {r_p, 1'b0};
  assign rd_addr_b    = {r_p, 1'b1};
  assign sel_valid    = r_sr[PIPE_LAT-1];
  assign result_class = r_result;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_knn_ctrl.sv
// Bench for knn_ctrl: default-size and minimum-size instances share the same
// stimulus; each is compared every cycle against a pass-offset timing model.
module tb_knn_ctrl;

  logic clk;
  logic reset, start, abort;
  logic [1:0] class1, class2, class3, class4, class5;

  logic       rd_en_0, sel_reset_0, sel_valid_0, busy_0, done_0;
  logic [5:0] rd_addr_a_0, rd_addr_b_0;
  logic [1:0] result_0;
  logic [2:0] dbg_0;

  logic       rd_en_1, sel_reset_1, sel_valid_1, busy_1, done_1;
  logic [2:0] rd_addr_a_1, rd_addr_b_1;
  logic [1:0] result_1;
  logic [2:0] dbg_1;

  knn_ctrl #(.N_TRAIN(64), .ADDR_W(6), .PIPE_LAT(3)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_en(rd_en_0), .rd_addr_a(rd_addr_a_0), .rd_addr_b(rd_addr_b_0),
    .sel_reset(sel_reset_0), .sel_valid(sel_valid_0),
    .class1(class1), .class2(class2), .class3(class3), .class4(class4), .class5(class5),
    .busy(busy_0), .done(done_0), .result_class(result_0), .dbg_state(dbg_0)
  );

  knn_ctrl #(.N_TRAIN(6), .ADDR_W(3), .PIPE_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rd_en(rd_en_1), .rd_addr_a(rd_addr_a_1), .rd_addr_b(rd_addr_b_1),
    .sel_reset(sel_reset_1), .sel_valid(sel_valid_1),
    .class1(class1), .class2(class2), .class3(class3), .class4(class4), .class5(class5),
    .busy(busy_1), .done(done_1), .result_class(result_1), .dbg_state(dbg_1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  logic force_en = 1'b0;
  logic [9:0] force_cls = '0;

  // model state: k = cycles since the start was accepted (-1 = idle)
  int np_m [2] = '{32, 3};
  int lat_m[2] = '{3, 1};
  int k_m  [2] = '{-1, -1};
  int haddr_m[2] = '{0, 0};
  logic [1:0] res_m[2] = '{2'd0, 2'd0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] vote(input logic [9:0] c);
    int cnt[4];
    int mx;
    logic [1:0] v;
    for (int j = 0; j < 4; j++) cnt[j] = 0;
    for (int i = 0; i < 5; i++) begin
      v = c[9-2*i -: 2];
      cnt[v]++;
    end
    mx = 0;
    for (int j = 0; j < 4; j++) if (cnt[j] > mx) mx = cnt[j];
    for (int i = 0; i < 5; i++) begin
      v = c[9-2*i -: 2];
      if (cnt[v] == mx) return v;
    end
    return 2'd0;
  endfunction

  task automatic check_dut(input int d, input logic o_rd_en, input logic [31:0] o_a,
                           input logic [31:0] o_b, input logic o_srst, input logic o_sv,
                           input logic o_busy, input logic o_done, input logic [1:0] o_res);
    int k, np, lat, dn, ea;
    logic e_rd;
    k = k_m[d]; np = np_m[d]; lat = lat_m[d];
    dn = np + lat + 4;
    e_rd = (k >= 2 && k <= np + 1);
    ea = e_rd ? 2 * (k - 2) : haddr_m[d];
    check($sformatf("d%0d_busy", d),      32'(o_busy),  32'(k >= 1));
    check($sformatf("d%0d_sel_reset", d), 32'(o_srst),  32'(k == 1));
    check($sformatf("d%0d_rd_en", d),     32'(o_rd_en), 32'(e_rd));
    check($sformatf("d%0d_rd_addr_a", d), o_a,          32'(ea));
    check($sformatf("d%0d_rd_addr_b", d), o_b,          32'(ea + 1));
    check($sformatf("d%0d_sel_valid", d), 32'(o_sv),    32'(k >= 2 + lat && k <= np + 1 + lat));
    check($sformatf("d%0d_done", d),      32'(o_done),  32'(k == dn));
    check($sformatf("d%0d_result", d),    32'(o_res),   32'(res_m[d]));
    // advance model with this cycle's inputs
    if (e_rd) haddr_m[d] = ea;
    if (reset) begin
      k_m[d] = -1; haddr_m[d] = 0; res_m[d] = 2'd0;
    end else if (abort) begin
      k_m[d] = -1;
    end else if (k < 0) begin
      if (start) k_m[d] = 1;
    end else begin
      if (k == dn - 1) res_m[d] = vote({class1, class2, class3, class4, class5});
      k_m[d] = (k == dn) ? -1 : k + 1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_dut(0, rd_en_0, 32'(rd_addr_a_0), 32'(rd_addr_b_0), sel_reset_0, sel_valid_0,
                busy_0, done_0, result_0);
      check_dut(1, rd_en_1, 32'(rd_addr_a_1), 32'(rd_addr_b_1), sel_reset_1, sel_valid_1,
                busy_1, done_1, result_1);
    end
  end

  // driver
  task automatic tick(input logic s, input logic a, input logic r);
    @(posedge clk);
    #1;
    start = s; abort = a; reset = r;
    if (force_en) begin
      {class1, class2, class3, class4, class5} = force_cls;
    end else begin
      class1 = 2'($urandom_range(0, 3)); class2 = 2'($urandom_range(0, 3));
      class3 = 2'($urandom_range(0, 3)); class4 = 2'($urandom_range(0, 3));
      class5 = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic vote_pass(input logic [9:0] cls, input logic [1:0] want, input string tag);
    force_en = 1'b1; force_cls = cls;
    tick(1'b1, 1'b0, 1'b0);
    repeat (44) tick(1'b0, 1'b0, 1'b0);
    check({tag, "_big"},   32'(result_0), 32'(want));
    check({tag, "_small"}, 32'(result_1), 32'(want));
    force_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    {class1, class2, class3, class4, class5} = '0;
    tick(1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    vote_pass({2'd2, 2'd2, 2'd1, 2'd2, 2'd3}, 2'd2, "vote_majority");
    vote_pass({2'd1, 2'd3, 2'd3, 2'd1, 2'd0}, 2'd1, "vote_tie");
    vote_pass({2'd0, 2'd1, 2'd2, 2'd3, 2'd3}, 2'd3, "vote_pair");

    // start held high continuously
    repeat (130) tick(1'b1, 1'b0, 1'b0);
    repeat (45) tick(1'b0, 1'b0, 1'b0);

    // abort in cycle 20 of a pass
    tick(1'b1, 1'b0, 1'b0);
    repeat (19) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b0);

    // reset in cycle 10, then a full pass
    tick(1'b1, 1'b0, 1'b0);
    repeat (9) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    repeat (45) tick(1'b0, 1'b0, 1'b0);

    // abort together with start in IDLE
    tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    // random traffic
    repeat (1500) tick($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                       $urandom_range(0, 299) == 0);
    repeat (50) tick(1'b0, 1'b0, 1'b0);

    mon_en = 1'b0;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/knn_ctrl.md
# knn_ctrl

Sequencing controller for one k-NN classification pass. On `start`, it clears the top-5 selector (`k_sel`) and walks the training-sample memory two entries per cycle. It raises the selector's `valid` aligned with the distance datapath output, waits for the pipeline to drain, then takes a majority vote over the five nearest classes. The block sits between the query front end and the `rd_addr`/`sel_*` side of the memory → distance-unit → `k_sel` datapath.

## Interface
Parameters:
- `N_TRAIN`, 64: number of training samples; even, ≥ 6.
- `ADDR_W`, 6: training-memory address width; 2^ADDR_W ≥ N_TRAIN.
- `PIPE_LAT`, 3: cycles from `rd_en` to the matching distance pair at `k_sel` inputs; ≥ 1.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a pass; sampled only in IDLE.
- `abort`  in  1  terminate the current pass; returns to IDLE without `done`.
- `rd_en`  out  1  training-memory read strobe.
- `rd_addr_a`  out  ADDR_W  even-sample address.
- `rd_addr_b`  out  ADDR_W  odd-sample address (`rd_addr_a`+1).
- `sel_reset`  out  1  drives `k_sel` reset.
- `sel_valid`  out  1  drives `k_sel` valid.
- `class1`..`class5`  in  2 each  `k_sel` outputs, nearest first.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `result_class`  out  2  voted class; held until the next `done`.

## Operation
- States: IDLE → CLEAR → ISSUE → DRAIN → VOTE → DONE → IDLE.
- IDLE:
  - `start`=1 → CLEAR.
  - `start` in any other state is ignored (no queuing).
- CLEAR: one cycle, `sel_reset`=1.
- ISSUE: N_TRAIN/2 cycles.
  - Pair counter `p` runs 0..N_TRAIN/2−1.
  - `rd_en`=1, `rd_addr_a`=2p, `rd_addr_b`=2p+1.
  - Leaves ISSUE after `p`=N_TRAIN/2−1.
- `sel_valid` = `rd_en` delayed by exactly PIPE_LAT cycles through a shift register. The shift register clears on reset, abort and CLEAR.
- DRAIN: PIPE_LAT+1 cycles.
- VOTE: one cycle.
  - Count occurrences of each class 0..3 among `class1`..`class5` (3-bit counts).
  - Winner is the max count.
  - Tie (e.g. 2-2-1): the tied class appearing at the lowest index `classN` wins.
  - Register the winner into `result_class`.
- DONE: one cycle, `done`=1, then IDLE.
- `abort` (any non-IDLE state): next cycle is IDLE. `rd_en`, `sel_valid` and the shift register clear, `done` stays 0, `result_class` is unchanged.
- `abort` and `start` together in IDLE: `abort` wins, stay IDLE.
- Reset values: state IDLE, `p`=0, `rd_en`=0, `rd_addr_a`=0, `rd_addr_b`=1, `sel_reset`=0, `sel_valid`=0, `busy`=0, `done`=0, `result_class`=0.
- `rd_addr_a`/`rd_addr_b` hold their last value when `rd_en`=0.

## Timing
- `start` sampled high in cycle 0. Then:
  - CLEAR in cycle 1.
  - ISSUE in cycles 2..N_TRAIN/2+1.
  - DRAIN in cycles N_TRAIN/2+2..N_TRAIN/2+PIPE_LAT+2.
  - VOTE in cycle N_TRAIN/2+PIPE_LAT+3.
  - `done` in cycle N_TRAIN/2+PIPE_LAT+4.
- Defaults (64, 3): `done` in cycle 39.
- `sel_valid` is high in cycles 2+PIPE_LAT..N_TRAIN/2+1+PIPE_LAT, i.e. exactly N_TRAIN/2 cycles, contiguous.
- The last `k_sel` update is visible one cycle before VOTE (one cycle of slack).
- `busy` rises in cycle 1 and falls in the cycle after DONE.
- Earliest back-to-back: `start` high in the DONE cycle is ignored. `start` is accepted the following cycle (IDLE).
- Reset mid-pass: next cycle all outputs are at reset values. `sel_reset` is not asserted by the controller; system reset clears `k_sel` directly.

## Test plan
- Defaults, single `start`:
  - `sel_reset` high only in cycle 1.
  - Addresses (0,1)..(62,63) in cycles 2..33.
  - `sel_valid` in cycles 5..36.
  - `done` in cycle 39, `busy` low in cycle 40.
- Vote: model classes {2,2,1,2,3} → `result_class`=2; {1,3,3,1,0} → `result_class`=1 (tie, `class1` earliest); {0,1,2,3,3} → 3.
- `start` held high continuously: passes separated by exactly one IDLE cycle, each `done` 39 cycles after its accept; `start` during a pass is ignored.
- `abort` in cycle 20: cycle 21 IDLE, `rd_en`=`sel_valid`=0, no `done`, `result_class` keeps the prior value.
- `reset` in cycle 10 of a pass: cycle 11 all outputs at reset values; a new `start` gives a full-length pass.
- Parameter sweep N_TRAIN=6, PIPE_LAT=1: three address pairs, `sel_valid` in cycles 3..5, `done` in cycle 8.
